pk_status_tx: RTL and testbench

- Control-panel status reporter. It sits downstream of the control panel and upstream of the UART transmitter.
- On request, it snapshots the panel display state: data bus W, indicator dots, P/MC flags and the rotary position code.
- It serialises the snapshot into a 6-byte tagged frame and hands the bytes one at a time to the UART transmitter via a send/busy handshake.
- It answers the host's "send LEDs" command, which is command class 3'b110.

---
 rtl/pk_status_tx.sv | 176 +++++++++++++++++
 tb/tb_pk_status_tx.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pk_status_tx.sv
// Control-panel status reporter: snapshots the panel display on request and streams it as a
// 6-byte tagged frame to a UART transmitter. Define PK_AUTO_REPORT_EN for periodic auto-reports.
module pk_status_tx #(
    parameter int FRAME_LEN     = 6
`ifdef PK_AUTO_REPORT_EN
    ,
    parameter int REPORT_PERIOD = 50_000_000
`endif
) (
    input  logic        CLK_EXT,
    input  logic        rst,
    input  logic        req,
    input  logic [0:15] w,
    input  logic [7:0]  dots,
    input  logic        p_,
    input  logic        mc_,
    input  logic [3:0]  rot,
    input  logic        tx_busy,
    output logic [7:0]  tx_byte,
    output logic        tx_send,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_ARM,
        S_WAIT
    } state_t;

    // Flags are stored active-high so the frame carries them in that polarity.
    typedef struct packed {
        logic [15:0] w;
        logic [7:0]  dots;
        logic        p;
        logic        mc;
        logic [3:0]  rot;
    } snap_t;

    localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

    state_t     state;
    state_t     state_next;
    snap_t      snap;
    logic [2:0] idx;
    logic       pending;
    logic [7:0] last_byte;
    logic [7:0] cur_byte;
    logic       any_req;
    logic       load;
    logic       strobe;
    logic       advance;
    logic       finish;

`ifdef PK_AUTO_REPORT_EN
    localparam int CNT_W = (REPORT_PERIOD > 1) ? $clog2(REPORT_PERIOD) : 1;

    logic [CNT_W-1:0] period_cnt;
    logic             auto_tick;

    assign auto_tick = (period_cnt == CNT_W'(REPORT_PERIOD - 1));

    // A host request restarts the interval so auto-reports never crowd a host report.
    always_ff @(posedge CLK_EXT) begin
        if (rst || req || auto_tick) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

    assign any_req = req | auto_tick;
`else
    assign any_req = req;
`endif

    always_ff @(posedge CLK_EXT) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        strobe     = 1'b0;
        advance    = 1'b0;
        finish     = 1'b0;
        case (state)
            S_IDLE: begin
                if (any_req || pending) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                load       = 1'b1;
                state_next = S_SEND;
            end
            S_SEND: begin
                if (!tx_busy) begin
                    strobe     = 1'b1;
                    state_next = S_ARM;
                end
            end
            // The UART raises tx_busy one cycle after the strobe, so skip a cycle before trusting it.
            S_ARM: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (!tx_busy) begin
                    if (idx == LAST_IDX) begin
                        finish     = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        advance    = 1'b1;
                        state_next = S_SEND;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        cur_byte = 8'h00;
        case (idx)
            3'd0:    cur_byte = {3'd0, snap.w[15:11]};
            3'd1:    cur_byte = {3'd1, snap.w[10:6]};
            3'd2:    cur_byte = {3'd2, snap.w[5:1]};
            3'd3:    cur_byte = {3'd3, snap.w[0], snap.dots[7:4]};
            3'd4:    cur_byte = {3'd4, snap.dots[3:0], snap.p};
            3'd5:    cur_byte = {3'd5, snap.mc, snap.rot};
            default: cur_byte = 8'h00;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge CLK_EXT) begin
        if (rst) begin
            snap       <= '0;
            idx        <= '0;
            pending    <= 1'b0;
            last_byte  <= 8'h00;
            frame_done <= 1'b0;
        end else begin
            frame_done <= finish;
            if (load) begin
                snap <= {w, dots, ~p_, ~mc_, rot};
                idx  <= '0;
            end else if (advance) begin
                idx <= idx + 3'd1;
            end
            if (strobe) begin
                last_byte <= cur_byte;
            end
            // One-deep: requests while busy merge into a single follow-up frame.
            if (busy && any_req) begin
                pending <= 1'b1;
            end else if (load) begin
                pending <= 1'b0;
            end
        end
    end

    assign busy    = (state != S_IDLE);
    assign tx_send = strobe;
    assign tx_byte = strobe ? cur_byte : last_byte;

endmodule

// File: tb/tb_pk_status_tx.sv
// Self-checking bench for pk_status_tx: a procedural frame model checked every cycle,
// plus directed scenarios with hand-computed frames.
module tb_pk_status_tx;

    localparam int FRAME_LEN = 6;

    typedef logic [7:0] frame_t [FRAME_LEN];

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [0:15] w;
    logic [7:0]  dots;
    logic        p_;
    logic        mc_;
    logic [3:0]  rot;
    logic        tx_busy;
    logic [7:0]  tx_byte;
    logic        tx_send;
    logic        busy;
    logic        frame_done;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit hold_busy = 1'b0;

    logic [7:0] cap[$];
    int         cap_cyc[$];
    int         send_cnt = 0;
    int         done_cnt = 0;

    logic       m_valid = 1'b0;
    logic       m_busy, m_send, m_done;
    logic [7:0] m_byte;
    logic [7:0] m_last;
    bit         m_pend, m_done_next;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pk_status_tx #(
        .FRAME_LEN(FRAME_LEN)
`ifdef PK_AUTO_REPORT_EN
        ,
        .REPORT_PERIOD(1000)
`endif
    ) dut (
        .CLK_EXT   (clk),
        .rst       (rst),
        .req       (req),
        .w         (w),
        .dots      (dots),
        .p_        (p_),
        .mc_       (mc_),
        .rot       (rot),
        .tx_busy   (tx_busy),
        .tx_byte   (tx_byte),
        .tx_send   (tx_send),
        .busy      (busy),
        .frame_done(frame_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // UART stand-in: busy for 3 cycles, starting two cycles after each strobe.
    initial begin : uart
        int left;
        bit st, raise;
        left = 0; raise = 1'b0; st = 1'b0; tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            st = (tx_send === 1'b1);
            @(posedge clk); #2;
            if (raise) begin left = 3; raise = 1'b0; end
            if (st) raise = 1'b1;
            tx_busy = hold_busy || (left > 0);
            if (left > 0) left--;
        end
    end

    always @(negedge clk) begin
        if (tx_send === 1'b1) begin
            cap.push_back(tx_byte);
            cap_cyc.push_back(cyc);
            send_cnt++;
        end
        if (frame_done === 1'b1) done_cnt++;
    end

    // Records what this cycle must show; returns 1 when rst ends whatever is in progress.
    function automatic bit expect_cycle(input bit b, input bit s, input logic [7:0] sb);
        m_valid     = 1'b1;
        m_busy      = b;
        m_send      = s;
        m_byte      = s ? sb : m_last;
        m_done      = m_done_next;
        m_done_next = 1'b0;
        if (s) m_last = sb;
        if (b && req) m_pend = 1'b1;
        if (rst) begin
            m_pend = 1'b0; m_last = 8'h00; m_done_next = 1'b0;
        end
        return rst;
    endfunction

    initial begin : model
        bit ab, go;
        logic [7:0] fb [FRAME_LEN];
        m_pend = 1'b0; m_last = 8'h00; m_done_next = 1'b0;
        forever begin
            @(negedge clk);
            go = req || m_pend;
            if (expect_cycle(1'b0, 1'b0, 8'h00) || !go) continue;
            @(negedge clk);
            fb[0] = {3'd0, w[0:4]};
            fb[1] = {3'd1, w[5:9]};
            fb[2] = {3'd2, w[10:14]};
            fb[3] = {3'd3, w[15], dots[7:4]};
            fb[4] = {3'd4, dots[3:0], ~p_};
            fb[5] = {3'd5, ~mc_, rot};
            m_pend = 1'b0;
            if (expect_cycle(1'b1, 1'b0, 8'h00)) continue;
            ab = 1'b0;
            for (int i = 0; i < FRAME_LEN && !ab; i++) begin
                do begin
                    @(negedge clk);
                    go = !tx_busy;
                    ab = expect_cycle(1'b1, go, fb[i]);
                end while (!go && !ab);
                if (ab) break;
                @(negedge clk);
                ab = expect_cycle(1'b1, 1'b0, 8'h00);
                if (ab) break;
                do begin
                    @(negedge clk);
                    go = !tx_busy;
                    ab = expect_cycle(1'b1, 1'b0, 8'h00);
                end while (!go && !ab);
                if (!ab && i == FRAME_LEN - 1) m_done_next = 1'b1;
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk); #1;
            if (m_valid) begin
                check("cycle busy", busy, m_busy);
                check("cycle tx_send", tx_send, m_send);
                check("cycle tx_byte", tx_byte, m_byte);
                check("cycle frame_done", frame_done, m_done);
            end
        end
    end

    task automatic drive_tick();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        @(negedge clk); #2;
    endtask

    task automatic pulse_req();
        req = 1'b1;
        drive_tick();
        req = 1'b0;
    endtask

    task automatic clear_log();
        cap.delete(); cap_cyc.delete();
        send_cnt = 0; done_cnt = 0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        int t = 0;
        while (done_cnt < n && t < budget) begin drive_tick(); t++; end
        check($sformatf("%0d frame_done within budget", n), done_cnt >= n, 1);
    endtask

    task automatic wait_sends(input int n, input int budget);
        int t = 0;
        while (cap.size() < n && t < budget) begin drive_tick(); t++; end
        check($sformatf("%0d strobes within budget", n), cap.size() >= n, 1);
    endtask

    task automatic check_frame(input string tag, input int base, input frame_t exp_f);
        for (int i = 0; i < FRAME_LEN; i++) begin
            check($sformatf("%s B%0d", tag, i),
                  (base + i < cap.size()) ? cap[base + i] : 8'hxx, exp_f[i]);
        end
    endtask

    initial begin : stimulus
        // w=A5C3, dots=81, p_=0, mc_=1, rot=9
        frame_t exp_a = '{8'h14, 8'h37, 8'h41, 8'h78, 8'h83, 8'hA9};
        // w=0F0F, dots=3C, p_=1, mc_=0, rot=15
        frame_t exp_b = '{8'h01, 8'h3C, 8'h47, 8'h73, 8'h98, 8'hBF};
        int t0, n, t_rel;

        rst = 1'b1; req = 1'b0; w = '0; dots = 8'h00; p_ = 1'b1; mc_ = 1'b1; rot = 4'd0;
        repeat (3) drive_tick();
        rst = 1'b0;
        settle();
        check("reset tx_byte", tx_byte, 8'h00);
        check("reset tx_send", tx_send, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset frame_done", frame_done, 1'b0);

        // Basic frame, latency and snapshot stability.
        w = 16'hA5C3; dots = 8'h81; p_ = 1'b0; mc_ = 1'b1; rot = 4'd9;
        clear_log();
        drive_tick();
        t0 = cyc;
        pulse_req();
        settle();
        check("latency N+1 tx_send", tx_send, 1'b0);
        drive_tick();
        settle();
        check("latency N+2 tx_send", tx_send, 1'b1);
        check("latency N+2 tx_byte", tx_byte, 8'h14);
        drive_tick();
        w = 16'hFFFF;
        wait_frames(1, 200);
        repeat (3) drive_tick();
        settle();
        check_frame("basic", 0, exp_a);
        check("basic first strobe cycle", cap_cyc.size() > 0 ? cap_cyc[0] - t0 : -1, 2);
        check("basic strobes", send_cnt, 6);
        check("basic frame_done count", done_cnt, 1);
        check("basic busy after", busy, 1'b0);

        // Three requests during a frame merge into one follow-up frame.
        drive_tick();
        clear_log();
        w = 16'h1234; dots = 8'h00; p_ = 1'b1; mc_ = 1'b1; rot = 4'd0;
        pulse_req();
        repeat (3) drive_tick(); pulse_req();
        repeat (5) drive_tick(); pulse_req();
        repeat (5) drive_tick(); pulse_req();
        repeat (5) drive_tick();
        w = 16'h0F0F; dots = 8'h3C; p_ = 1'b1; mc_ = 1'b0; rot = 4'd15;
        wait_frames(2, 400);
        repeat (60) drive_tick();
        check("merge frame_done count", done_cnt, 2);
        check("merge strobes", send_cnt, 12);
        check("merge first B0", cap.size() > 0 ? cap[0] : 8'hxx, 8'h02);
        check_frame("merge second", 6, exp_b);

        // Backpressure before B2.
        clear_log();
        w = 16'hA5C3; dots = 8'h81; p_ = 1'b0; mc_ = 1'b1; rot = 4'd9;
        pulse_req();
        wait_sends(2, 100);
        hold_busy = 1'b1;
        n = send_cnt;
        repeat (100) drive_tick();
        check("backpressure no strobe", send_cnt, n);
        hold_busy = 1'b0;
        t_rel = cyc;
        wait_frames(1, 200);
        repeat (3) drive_tick();
        check("backpressure B2 cycle", cap_cyc.size() > 2 ? cap_cyc[2] - t_rel : -1, 1);
        check("backpressure strobes", send_cnt, 6);
        check_frame("backpressure", 0, exp_a);

        // Reset right after B3 is strobed.
        clear_log();
        pulse_req();
        wait_sends(4, 100);
        rst = 1'b1;
        drive_tick();
        rst = 1'b0;
        settle();
        check("abort tx_send", tx_send, 1'b0);
        check("abort busy", busy, 1'b0);
        check("abort frame_done", frame_done, 1'b0);
        check("abort tx_byte", tx_byte, 8'h00);
        repeat (40) drive_tick();
        check("abort no frame_done", done_cnt, 0);
        check("abort strobes", send_cnt, 4);
        clear_log();
        pulse_req();
        wait_frames(1, 200);
        repeat (3) drive_tick();
        check("after abort strobes", send_cnt, 6);
        check_frame("after abort", 0, exp_a);

`ifndef PK_AUTO_REPORT_EN
        clear_log();
        repeat (1200) drive_tick();
        check("idle no report", send_cnt, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
